// File: rtl/ddr_cmd_scheduler_pkg.sv
// Shared DDR command scheduler types and default timing.
// Timing defaults are common with the per-bank TimingFSM.
package ddr_cmd_pkg;

  localparam int T_CL_DEF  = 17;
  localparam int T_RCD_DEF = 17;
  localparam int T_WR_DEF  = 14;
  localparam int T_RP_DEF  = 17;
  localparam int T_RFC_DEF = 34;
  localparam int TMR_W     = 8;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_RDA,
    CMD_WR,
    CMD_WRA,
    CMD_PR,
    CMD_PRA,
    CMD_REF
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACTV,
    S_WAIT_RCD,
    S_CAS,
    S_WAIT_CAS,
    S_WAIT_APRE,
    S_REF_PRA,
    S_WAIT_PRA,
    S_REFR,
    S_WAIT_RFC
  } sched_state_e;

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Request handshake bundle between initiator and scheduler.
// One read/write request per valid/ready handshake.
interface ddr_cmd_scheduler_if #(
  parameter int BGW      = 2,
  parameter int BAWIDTH  = 2,
  parameter int ROWWIDTH = 16
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic                req_autopre;
  logic [BGW-1:0]      req_bg;
  logic [BAWIDTH-1:0]  req_ba;
  logic [ROWWIDTH-1:0] req_row;

  modport master (
    output req_valid, req_write, req_autopre,
    output req_bg, req_ba, req_row,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_write, req_autopre,
    input  req_bg, req_ba, req_row,
    output req_ready
  );
endinterface

// File: rtl/ddr_cmd_scheduler_open_row_table.sv
// Open-row table: per-bank {valid,row} with combinational lookup.
// Writes come only from the scheduler FSM.
module open_row_table
  import ddr_cmd_pkg::*;
#(
  parameter int IW       = 4,
  parameter int ROWWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IW-1:0]       lk_idx,
  input  logic [ROWWIDTH-1:0] lk_row,
  output logic                lk_hit,
  output logic                lk_miss,
  output logic                any_open,
  input  logic [IW-1:0]       wr_idx,
  input  logic                set_en,
  input  logic [ROWWIDTH-1:0] set_row,
  input  logic                clr_en,
  input  logic                clr_all
);
  localparam int N = 1 << IW;

  logic [N-1:0]        vld_q;
  logic [ROWWIDTH-1:0] row_q [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++)
        row_q[i] <= '0;
    end else if (clr_all) begin
      vld_q <= '0;
    end else if (set_en) begin
      vld_q[wr_idx] <= 1'b1;
      row_q[wr_idx] <= set_row;
    end else if (clr_en) begin
      vld_q[wr_idx] <= 1'b0;
    end
  end

  always_comb begin
    lk_hit   = vld_q[lk_idx] && (row_q[lk_idx] == lk_row);
    lk_miss  = vld_q[lk_idx] && (row_q[lk_idx] != lk_row);
    any_open = |vld_q;
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: spaces ACT/RD/WR/PR/REF for the bank FSMs
// and tracks open rows so hits skip ACT and misses insert PR.
module ddr_cmd_scheduler
  import ddr_cmd_pkg::*;
#(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int ROWWIDTH = 16,
  parameter int T_CL     = T_CL_DEF,
  parameter int T_RCD    = T_RCD_DEF,
  parameter int T_WR     = T_WR_DEF,
  parameter int T_RP     = T_RP_DEF,
  parameter int T_RFC    = T_RFC_DEF,
  localparam int BGW     = (BGWIDTH == 0) ? 1 : BGWIDTH,
  localparam int IW      = BGWIDTH + BAWIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  ddr_cmd_scheduler_if.slave  rq,
  input  logic                ref_req,
  output logic                ref_ack,
  output logic                done,
  output logic                ACT,
  output logic                RD,
  output logic                RDA,
  output logic                WR,
  output logic                WRA,
  output logic                PR,
  output logic                PRA,
  output logic                REF,
  output logic [BGW-1:0]      bg,
  output logic [BAWIDTH-1:0]  ba,
  output logic [ROWWIDTH-1:0] row
);
  // Waits followed by an issue state load T-2 (the issue state adds
  // a cycle); terminal waits load T-1 so done/IDLE land exactly at T.
  localparam logic [TMR_W-1:0] LD_RP2  = TMR_W'(T_RP - 2);
  localparam logic [TMR_W-1:0] LD_RCD2 = TMR_W'(T_RCD - 2);
  localparam logic [TMR_W-1:0] LD_CL1  = TMR_W'(T_CL - 1);
  localparam logic [TMR_W-1:0] LD_WR1  = TMR_W'(T_WR - 1);
  localparam logic [TMR_W-1:0] LD_RP1  = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] LD_RFC1 = TMR_W'(T_RFC - 1);

  sched_state_e        state_q, state_d;
  cmd_e                cmd_q, cmd_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;
  logic [BGW-1:0]      cbg_q, cbg_d;
  logic [BAWIDTH-1:0]  cba_q, cba_d;
  logic [ROWWIDTH-1:0] crow_q, crow_d;

  logic                wr_q, ap_q;
  logic [BGW-1:0]      bg_q;
  logic [BAWIDTH-1:0]  ba_q;
  logic [ROWWIDTH-1:0] row_q;

  logic                acc;
  logic                lk_hit, lk_miss, any_open;
  logic                set_en, clr_en, clr_all;
  logic [IW-1:0]       lk_idx, wr_idx;
  logic                tmr_zero;

  if (BGWIDTH == 0) begin : g_nobg
    assign lk_idx = rq.req_ba;
    assign wr_idx = ba_q;
  end else begin : g_bg
    assign lk_idx = {rq.req_bg, rq.req_ba};
    assign wr_idx = {bg_q, ba_q};
  end

  open_row_table #(
    .IW       (IW),
    .ROWWIDTH (ROWWIDTH)
  ) u_ort (
    .clk      (clk),
    .reset_n  (reset_n),
    .lk_idx   (lk_idx),
    .lk_row   (rq.req_row),
    .lk_hit   (lk_hit),
    .lk_miss  (lk_miss),
    .any_open (any_open),
    .wr_idx   (wr_idx),
    .set_en   (set_en),
    .set_row  (row_q),
    .clr_en   (clr_en),
    .clr_all  (clr_all)
  );

  assign rq.req_ready = (state_q == S_IDLE) && !ref_req;
  assign tmr_zero     = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_zero ? '0 : tmr_q - 1'b1;
    cmd_d   = CMD_NOP;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    cbg_d   = cbg_q;
    cba_d   = cba_q;
    crow_d  = crow_q;
    acc     = 1'b0;
    set_en  = 1'b0;
    clr_en  = 1'b0;
    clr_all = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = any_open ? S_REF_PRA : S_REFR;
        end else if (rq.req_valid) begin
          acc = 1'b1;
          unique case (1'b1)
            lk_hit:  state_d = S_CAS;
            lk_miss: state_d = S_PRE;
            default: state_d = S_ACTV;
          endcase
        end
      end
      S_PRE: begin
        cmd_d   = CMD_PR;
        cbg_d   = bg_q;
        cba_d   = ba_q;
        clr_en  = 1'b1;
        tmr_d   = LD_RP2;
        state_d = S_WAIT_RP;
      end
      S_WAIT_RP:
        if (tmr_zero) state_d = S_ACTV;
      S_ACTV: begin
        cmd_d   = CMD_ACT;
        cbg_d   = bg_q;
        cba_d   = ba_q;
        crow_d  = row_q;
        set_en  = 1'b1;
        tmr_d   = LD_RCD2;
        state_d = S_WAIT_RCD;
      end
      S_WAIT_RCD:
        if (tmr_zero) state_d = S_CAS;
      S_CAS: begin
        unique case ({wr_q, ap_q})
          2'b00:   cmd_d = CMD_RD;
          2'b01:   cmd_d = CMD_RDA;
          2'b10:   cmd_d = CMD_WR;
          default: cmd_d = CMD_WRA;
        endcase
        cbg_d   = bg_q;
        cba_d   = ba_q;
        tmr_d   = wr_q ? LD_WR1 : LD_CL1;
        state_d = S_WAIT_CAS;
      end
      S_WAIT_CAS:
        if (tmr_zero) begin
          if (ap_q) begin
            clr_en  = 1'b1;
            tmr_d   = LD_RP1;
            state_d = S_WAIT_APRE;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      S_WAIT_APRE:
        if (tmr_zero) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      S_REF_PRA: begin
        cmd_d   = CMD_PRA;
        cbg_d   = '0;
        cba_d   = '0;
        clr_all = 1'b1;
        tmr_d   = LD_RP2;
        state_d = S_WAIT_PRA;
      end
      S_WAIT_PRA:
        if (tmr_zero) state_d = S_REFR;
      S_REFR: begin
        cmd_d   = CMD_REF;
        cbg_d   = '0;
        cba_d   = '0;
        ack_d   = 1'b1;
        tmr_d   = LD_RFC1;
        state_d = S_WAIT_RFC;
      end
      S_WAIT_RFC:
        if (tmr_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cmd_q   <= CMD_NOP;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      cbg_q   <= '0;
      cba_q   <= '0;
      crow_q  <= '0;
      wr_q    <= 1'b0;
      ap_q    <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      cbg_q   <= cbg_d;
      cba_q   <= cba_d;
      crow_q  <= crow_d;
      if (acc) begin
        wr_q  <= rq.req_write;
        ap_q  <= rq.req_autopre;
        bg_q  <= rq.req_bg;
        ba_q  <= rq.req_ba;
        row_q <= rq.req_row;
      end
    end
  end

  assign ACT     = (cmd_q == CMD_ACT);
  assign RD      = (cmd_q == CMD_RD);
  assign RDA     = (cmd_q == CMD_RDA);
  assign WR      = (cmd_q == CMD_WR);
  assign WRA     = (cmd_q == CMD_WRA);
  assign PR      = (cmd_q == CMD_PR);
  assign PRA     = (cmd_q == CMD_PRA);
  assign REF     = (cmd_q == CMD_REF);
  assign ref_ack = ack_q;
  assign done    = done_q;
  assign bg      = (BGWIDTH == 0) ? '0 : cbg_q;
  assign ba      = cba_q;
  assign row     = crow_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler with a timed-event scoreboard.
// A bank model predicts every command pulse and its exact cycle.
module tb_ddr_cmd_scheduler;
  import ddr_cmd_pkg::*;

  localparam int TCL  = 17;
  localparam int TRCD = 17;
  localparam int TWR  = 14;
  localparam int TRP  = 17;
  localparam int TRFC = 34;
  localparam logic [3:0] EV_DONE = 4'hF;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] cyc;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ref_req = 1'b0;
  logic ref_ack, done;
  logic ACT, RD, RDA, WR, WRA, PR, PRA, REF;
  logic [1:0]  bg, ba;
  logic [15:0] row;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t sb[$];
  logic        mv[16];
  logic [15:0] mrow[16];

  ddr_cmd_scheduler_if #(.BGW(2), .BAWIDTH(2), .ROWWIDTH(16)) rq ();

  ddr_cmd_scheduler #(
    .BGWIDTH (2), .BAWIDTH (2), .ROWWIDTH (16),
    .T_CL (TCL), .T_RCD (TRCD), .T_WR (TWR), .T_RP (TRP), .T_RFC (TRFC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rq      (rq),
    .ref_req (ref_req),
    .ref_ack (ref_ack),
    .done    (done),
    .ACT     (ACT),
    .RD      (RD),
    .RDA     (RDA),
    .WR      (WR),
    .WRA     (WRA),
    .PR      (PR),
    .PRA     (PRA),
    .REF     (REF),
    .bg      (bg),
    .ba      (ba),
    .row     (row)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(logic [3:0] c, int t, int b, int a,
                               logic [15:0] r);
    ev_t e;
    e.code = c;
    e.cyc  = t;
    e.bg   = b[1:0];
    e.ba   = a[1:0];
    e.row  = (c == 4'(CMD_ACT)) ? r : 16'h0;
    sb.push_back(e);
  endfunction

  task automatic check_ev(logic [3:0] c, logic [1:0] b, logic [1:0] a,
                          logic [15:0] r);
    ev_t o, e;
    o.code = c;
    o.cyc  = cyc;
    o.bg   = b;
    o.ba   = a;
    o.row  = r;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_event obs=%h exp=none", o);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL event obs=%h exp=%h", o, e);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    logic [3:0] oc;
    if (reset_n) begin
      oc = ACT ? 4'(CMD_ACT) : RD ? 4'(CMD_RD) : RDA ? 4'(CMD_RDA) :
           WR ? 4'(CMD_WR) : WRA ? 4'(CMD_WRA) : PR ? 4'(CMD_PR) :
           PRA ? 4'(CMD_PRA) : REF ? 4'(CMD_REF) : 4'(CMD_NOP);
      if (oc != 4'(CMD_NOP) || ref_ack) begin
        chk("onehot", 32'($countones({ACT, RD, RDA, WR, WRA, PR, PRA, REF})),
            32'd1);
        chk("ref_ack", 32'(ref_ack), 32'(REF));
        check_ev(oc, bg, ba, ACT ? row : 16'h0);
      end
      if (done) check_ev(EV_DONE, 2'd0, 2'd0, 16'h0);
    end
  end

  task automatic expect_req(int acc, bit w, bit ap, int b, int a,
                            logic [15:0] r);
    int i, t;
    logic [3:0] c;
    i = b * 4 + a;
    t = acc + 1;
    if (!(mv[i] && mrow[i] == r)) begin
      if (mv[i]) begin
        push(4'(CMD_PR), t, b, a, 16'h0);
        t += TRP;
      end
      push(4'(CMD_ACT), t, b, a, r);
      t += TRCD;
    end
    c = w ? (ap ? 4'(CMD_WRA) : 4'(CMD_WR)) : (ap ? 4'(CMD_RDA) : 4'(CMD_RD));
    push(c, t, b, a, 16'h0);
    t += w ? TWR : TCL;
    if (ap) t += TRP;
    push(EV_DONE, t, 0, 0, 16'h0);
    mv[i]   = !ap;
    mrow[i] = r;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!rq.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(rq.req_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic drive(bit w, bit ap, int b, int a, logic [15:0] r);
    rq.req_valid   = 1'b1;
    rq.req_write   = w;
    rq.req_autopre = ap;
    rq.req_bg      = b[1:0];
    rq.req_ba      = a[1:0];
    rq.req_row     = r;
  endtask

  task automatic send(bit w, bit ap, int b, int a, logic [15:0] r,
                      output int acc);
    wait_ready();
    drive(w, ap, b, a, r);
    acc = cyc + 1;
    expect_req(acc, w, ap, b, a, r);
    @(negedge clk);
    rq.req_valid = 1'b0;
  endtask

  task automatic chk_quiet(string tag);
    chk(tag, {ACT, RD, RDA, WR, WRA, PR, PRA, REF, ref_ack, done,
              bg, ba, row}, 32'h0);
  endtask

  initial begin
    int acc, c, r, n;
    for (int i = 0; i < 16; i++) begin
      mv[i]   = 1'b0;
      mrow[i] = 16'h0;
    end
    drive(1'b0, 1'b0, 0, 0, 16'h0);
    rq.req_valid = 1'b0;
    #1;
    chk_quiet("reset_outputs");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_ready", 32'(rq.req_ready), 32'd1);
    chk_quiet("post_reset_outputs");

    send(1'b0, 1'b0, 1, 1, 16'h0042, acc);
    wait_drain();
    send(1'b1, 1'b0, 1, 1, 16'h0042, acc);
    wait_drain();
    send(1'b0, 1'b0, 1, 1, 16'h0100, acc);
    wait_drain();
    send(1'b1, 1'b1, 2, 3, 16'h0555, acc);
    wait_drain();
    send(1'b0, 1'b0, 2, 3, 16'h0555, acc);
    wait_drain();
    send(1'b0, 1'b1, 0, 0, 16'h1234, acc);
    wait_drain();

    // Refresh with banks open and a request pending.
    @(negedge clk);
    ref_req = 1'b1;
    drive(1'b0, 1'b0, 1, 1, 16'h0100);
    #1;
    chk("ready_during_ref", 32'(rq.req_ready), 32'd0);
    c = cyc;
    push(4'(CMD_PRA), c + 2, 0, 0, 16'h0);
    push(4'(CMD_REF), c + 2 + TRP, 0, 0, 16'h0);
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    wait_drain();
    ref_req = 1'b0;
    r = c + 2 + TRP;
    n = 0;
    while (!rq.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_after_ref", 32'(cyc), 32'(r + TRFC));
    expect_req(cyc + 1, 1'b0, 1'b0, 1, 1, 16'h0100);
    @(negedge clk);
    rq.req_valid = 1'b0;
    wait_drain();

    // Reset during WAIT_RCD.
    send(1'b0, 1'b0, 0, 2, 16'h0077, acc);
    n = 0;
    while (cyc < acc + 6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("act_seen", 32'(sb.size()), 32'd2);
    #2;
    reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    #1;
    chk_quiet("async_reset_outputs");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(rq.req_ready), 32'd1);
    repeat (60) @(negedge clk);
    chk("no_stray_events", 32'(sb.size()), 32'd0);
    send(1'b0, 1'b0, 1, 1, 16'h0100, acc);
    wait_drain();
    send(1'b0, 1'b0, 0, 2, 16'h0077, acc);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
